// File: rtl/reg_pipeline.sv
// Elastic register pipeline: DEPTH valid/ready stages with compaction under backpressure,
// synchronous flush, registered occupancy count and asynchronous active-high reset.
module reg_pipeline #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            r_valid;
  logic [CW-1:0]               r_count;

  logic [DEPTH:0]              w_ready;
  logic [DEPTH-1:0]            w_ld_valid;
  logic [DEPTH-1:0][WIDTH-1:0] w_ld_data;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [CW-1:0]               w_count_nxt;
  logic                        w_accept;

  // Ready ripples from the output back toward the input, so a bubble anywhere lets upstream advance.
  always_comb begin
    w_ready        = '0;
    w_ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--)
      w_ready[k] = !r_valid[k] || w_ready[k+1];
  end

  assign in_ready = w_ready[0] && !flush && !reset;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_ld_valid    = '0;
    w_ld_data     = '0;
    w_ld_valid[0] = w_accept;
    w_ld_data[0]  = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_ld_valid[k] = r_valid[k-1];
      w_ld_data[k]  = r_data[k-1];
    end
  end

  // Next valid vector and its popcount, so count tracks the state after every edge.
  always_comb begin
    w_valid_nxt = r_valid;
    w_count_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (flush)
        w_valid_nxt[k] = 1'b0;
      else if (w_ready[k])
        w_valid_nxt[k] = w_ld_valid[k];
      w_count_nxt = w_count_nxt + CW'(w_valid_nxt[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      r_count <= w_count_nxt;
      // Data only moves with a real beat; bubbles leave the register untouched.
      for (int k = 0; k < DEPTH; k++)
        if (w_ready[k] && w_ld_valid[k])
          r_data[k] <= w_ld_data[k];
    end
  end

  assign out_data  = r_data[DEPTH-1];
  assign out_valid = r_valid[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_reg_pipeline.sv
// Directed bench for reg_pipeline: a DEPTH=4 instance for the main sequence and a
// DEPTH=1 instance sharing clock/reset for the single-stage stream.
module tb_reg_pipeline;

  logic       clk;
  logic       reset;

  logic [7:0] a_in_data, a_out_data;
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [2:0] a_count;

  logic [7:0] b_in_data, b_out_data;
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [0:0] b_count;

  int tests = 0;
  int fails = 0;

  reg_pipeline #(.WIDTH(8), .DEPTH(4)) u_a (
    .clk(clk), .reset(reset),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .flush(a_flush), .count(a_count)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(1)) u_b (
    .clk(clk), .reset(reset),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .flush(b_flush), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] beats [4] = '{8'h09, 8'h0F, 8'hA5, 8'h3C};
  int         lat_cnt [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
  logic       lat_ov  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] lat_od  [8] = '{8'h00, 8'h00, 8'h00, 8'h09, 8'h0F, 8'hA5, 8'h3C, 8'h00};
  logic [7:0] fp_exp  [3] = '{8'hA3, 8'hA4, 8'h77};
  logic [7:0] rx [16];
  int         nrx, idx;
  logic       acc;

  initial begin
    reset = 1'b1;
    a_in_data = '0; a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    b_in_data = '0; b_in_valid = 0; b_out_ready = 0; b_flush = 0;

    // Reset state before any clock edge
    #1;
    chk("rst_ov",    a_out_valid, 0);
    chk("rst_od",    a_out_data, 8'h00);
    chk("rst_cnt",   a_count, 0);
    chk("rst_irdy",  a_in_ready, 0);
    chk("rst_b_ov",  b_out_valid, 0);

    // Beat offered while reset held must not be taken
    a_in_valid = 1; a_in_data = 8'h55; a_out_ready = 1;
    tick();
    chk("rst_noacc", a_count, 0);
    a_in_valid = 0; a_out_ready = 0;
    reset = 1'b0;
    repeat (5) tick();
    chk("idle_ov",   a_out_valid, 0);
    chk("idle_od",   a_out_data, 8'h00);
    chk("idle_cnt",  a_count, 0);
    chk("idle_irdy", a_in_ready, 1);

    // Latency / throughput stream
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = (i < 4);
      a_in_data  = (i < 4) ? beats[i] : 8'h00;
      #1;
      chk($sformatf("lat_irdy%0d", i), a_in_ready, 1);
      tick();
      chk($sformatf("lat_cnt%0d", i), a_count, lat_cnt[i]);
      chk($sformatf("lat_ov%0d", i), a_out_valid, lat_ov[i]);
      if (lat_ov[i]) chk($sformatf("lat_od%0d", i), a_out_data, lat_od[i]);
    end
    a_in_valid = 0;

    // Backpressure: compaction then stall at full
    a_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1;
      a_in_data  = 8'(i + 1);
      #1;
      chk($sformatf("bp_irdy%0d", i), a_in_ready, (i < 4));
      tick();
    end
    chk("bp_cnt",  a_count, 4);
    chk("bp_ov",   a_out_valid, 1);
    chk("bp_od",   a_out_data, 8'h01);
    chk("bp_irdy", a_in_ready, 0);
    a_out_ready = 1;
    #1;
    chk("bp_irdy_pop", a_in_ready, 1);
    idx = 4; nrx = 0;
    for (int it = 0; it < 12; it++) begin
      a_in_valid = (idx < 6);
      a_in_data  = 8'(idx + 1);
      #1;
      acc = a_in_valid && a_in_ready;
      if (a_out_valid && a_out_ready) begin
        rx[nrx] = a_out_data;
        nrx++;
      end
      tick();
      if (acc) idx++;
    end
    a_in_valid = 0;
    chk("bp_sent", idx, 6);
    chk("bp_nrx", nrx, 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("bp_rx%0d", i), rx[i], 8'(i + 1));
    chk("bp_cnt_end", a_count, 0);

    // Full with simultaneous push and pop
    a_out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1;
      a_in_data  = 8'hA1 + 8'(i);
      tick();
    end
    chk("fp_cnt_full", a_count, 4);
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'h77;
    #1;
    chk("fp_irdy", a_in_ready, 1);
    chk("fp_od0",  a_out_data, 8'hA1);
    tick();
    a_in_valid = 0;
    chk("fp_cnt", a_count, 4);
    chk("fp_od1", a_out_data, 8'hA2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fp_drain%0d", i), a_out_data, fp_exp[i]);
    end
    tick();
    chk("fp_cnt_end", a_count, 0);

    // Flush with three held beats and a beat offered
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1;
      a_in_data  = 8'hB1 + 8'(i);
      tick();
    end
    a_in_valid = 1; a_in_data = 8'hEE; a_flush = 1;
    #1;
    chk("fl_cnt_pre", a_count, 3);
    chk("fl_irdy",    a_in_ready, 0);
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl_cnt", a_count, 0);
    chk("fl_ov",  a_out_valid, 0);
    a_out_ready = 1;
    repeat (4) tick();
    chk("fl_noacc", a_count, 0);
    chk("fl_ov_end", a_out_valid, 0);

    // Asynchronous reset mid-stream with two beats held
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 8'hC1; tick();
    a_in_data = 8'hC2; tick();
    a_in_valid = 0;
    tick(); tick();
    chk("ar_cnt_pre", a_count, 2);
    chk("ar_ov_pre",  a_out_valid, 1);
    chk("ar_od_pre",  a_out_data, 8'hC1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ov",   a_out_valid, 0);
    chk("ar_cnt",  a_count, 0);
    chk("ar_od",   a_out_data, 8'h00);
    chk("ar_irdy", a_in_ready, 0);
    #2;
    reset = 1'b0;
    a_out_ready = 1; a_in_valid = 1; a_in_data = 8'hD1;
    tick();
    a_in_valid = 0;
    chk("ar_post_cnt", a_count, 1);
    chk("ar_post_ov",  a_out_valid, 0);
    repeat (3) tick();
    chk("ar_post_ov3", a_out_valid, 1);
    chk("ar_post_od3", a_out_data, 8'hD1);
    tick();
    chk("ar_post_end", a_count, 0);

    // Single-stage instance: same stream, no added latency
    b_out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      b_in_valid = (i < 4);
      b_in_data  = (i < 4) ? beats[i] : 8'h00;
      #1;
      chk($sformatf("d1_irdy%0d", i), b_in_ready, 1);
      tick();
      chk($sformatf("d1_ov%0d", i), b_out_valid, (i < 4));
      chk($sformatf("d1_cnt%0d", i), b_count, (i < 4));
      if (i < 4) chk($sformatf("d1_od%0d", i), b_out_data, beats[i]);
    end
    b_out_ready = 0; b_in_valid = 1; b_in_data = 8'h5A;
    tick();
    #1;
    chk("d1_full_irdy", b_in_ready, 0);
    chk("d1_full_od",   b_out_data, 8'h5A);
    b_in_valid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_pipeline.md
REG_PIPELINE -- requirements
Module: reg_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of register stages; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  WIDTH  upstream data beat.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  pipeline accepts a beat this cycle.
REQ-008 out_data  output  WIDTH  data of last stage.
REQ-009 out_valid  output  1  last stage holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts a beat this cycle.
REQ-011 flush  input  1  synchronous discard of all held beats.
REQ-012 count  output  $clog2(DEPTH+1)  number of stages currently holding a valid beat.

Function
REQ-013 Stage k (0..DEPTH-1) SHALL hold a WIDTH data register and a valid bit; stage 0 faces input, stage DEPTH-1 drives out_data/out_valid.
REQ-014 Stage k ready SHALL be: !valid[k] || ready[k+1]; ready[DEPTH] is out_ready; in_ready = ready[0] && !flush (combinational path out_ready -> in_ready permitted).
REQ-015 Input beat SHALL be accepted on a posedge where in_valid && in_ready; output beat SHALL be transferred where out_valid && out_ready.
REQ-016 On a posedge where ready[k], stage k SHALL load data/valid from stage k-1 (stage 0 from in_data/in_valid&&in_ready); otherwise stage k SHALL hold.
REQ-017 Data register of a stage SHALL load only when its incoming valid is 1 (no toggle on bubbles); valid bit always updates per REQ-016.
REQ-018 Latency: beat accepted at edge N into an empty pipeline with out_ready=1 SHALL appear with out_valid=1 after edge N+DEPTH-1 (first visible in cycle following that edge).
REQ-019 Throughput: with in_valid=1 and out_ready=1 continuously, one beat per cycle, no bubbles inserted.
REQ-020 Backpressure: with out_ready=0, beats SHALL compact toward the output; in_ready SHALL fall only when all DEPTH stages are valid.
REQ-021 Full and out_ready=1 in same cycle: in_ready=1, simultaneous output transfer and input accept, count unchanged.
REQ-022 Ordering SHALL be strict FIFO; no beat duplicated or dropped except by flush/reset.
REQ-023 flush=1 at a posedge SHALL clear every valid bit; no input accepted that cycle; out_valid may be 1 during the flush cycle but any transfer that cycle is still counted as completed by downstream.
REQ-024 count SHALL be a registered value equal to popcount of valid bits after each edge; range 0..DEPTH.
REQ-025 out_data SHALL equal last stage data register; meaningful only while out_valid=1.

Reset
REQ-026 reset=1 SHALL immediately, without clk, clear all valid bits, all data registers to 0, count to 0; out_valid=0, out_data=0.
REQ-027 While reset=1, in_ready SHALL be 0 and no beat accepted.
REQ-028 Reset asserted mid-stream SHALL discard all held beats; first edge after deassertion behaves as empty pipeline.

Verification
REQ-029 Reset: reset=1 at t=0, no clock edge -> out_valid=0, out_data=8'h00, count=0; release, in_valid=0 for 5 cycles -> all unchanged.
REQ-030 Latency/throughput (WIDTH=8, DEPTH=4): stream 8'h09,8'h0F,8'hA5,8'h3C with out_ready=1 -> 8'h09 at output 3 edges after acceptance, then one beat per cycle in order, count peaks at 4 then drains to 0.
REQ-031 Backpressure: out_ready=0, push 6 beats 8'h01..8'h06 -> in_ready falls after 4 accepted, count=4, out_data=8'h01; raise out_ready -> outputs 8'h01..8'h06 in order, none lost.
REQ-032 Full with simultaneous push/pop: full, out_ready=1, in_valid=1 with 8'h77 -> one beat out, 8'h77 accepted, count stays 4.
REQ-033 Flush: pipeline holding 3 beats, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, input beat not accepted.
REQ-034 Async reset mid-operation: assert reset between edges while count=2 -> out_valid=0, count=0 before next posedge; DEPTH=1 rerun of REQ-030 -> 1 beat/cycle, zero added latency beyond stage.
